conv_mac_stream: RTL and testbench
==================================

CONV_MAC_STREAM -- requirements
Module: conv_mac_stream

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: width of each activation and weight element.
REQ-002 The block SHALL have parameter K, default 3: kernel height and width.
REQ-003 The block SHALL have parameter CH, default 3: input channel count; terms per window N = K*K*CH (27 by default).
REQ-004 The block SHALL have parameter ACC_W, default 24: accumulator width; ACC_W >= 2*DATA_W + clog2(N).
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low. Ports SHALL be, one per line:
  clk  input  1  clock; all state updates on rising edge.
  rst_n  input  1  asynchronous active-low reset.
  clear  input  1  synchronous abort of the current window.
  signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
  shift  input  clog2(ACC_W)  right-shift applied to the final sum.
  in_valid  input  1  activation/weight pair valid.
  in_ready  output  1  block can accept a pair.
  in_data  input  DATA_W  activation element.
  in_weight  input  DATA_W  weight element.
  out_valid  output  1  result valid.
  out_ready  input  1  consumer accepts the result.
  out_data  output  DATA_W  scaled, saturated result.
  out_sat  output  1  out_data was clamped.
  busy  output  1  window in progress (state != IDLE).

Function
REQ-006 The block SHALL implement FSM states IDLE, ACCUM and HOLD.
REQ-007 A beat SHALL be accepted when in_valid && in_ready; in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-008 In IDLE, the first accepted beat SHALL load acc = product, set cnt = 1, and latch signed_mode and shift; next state is ACCUM, or HOLD if N == 1.
REQ-009 In ACCUM, each accepted beat SHALL add its product to acc and increment cnt; the beat making cnt == N SHALL move the block to HOLD.
REQ-010 Signed_mode and shift SHALL be ignored after the first beat until the next window.
REQ-011 The product SHALL be the 2*DATA_W-bit signed or unsigned product per latched mode, sign- or zero-extended to ACC_W; accumulation SHALL wrap modulo 2^ACC_W.
REQ-012 The final sum SHALL be shifted right by the latched shift: arithmetic in signed mode, logical in unsigned mode, truncating toward minus infinity.
REQ-013 Saturation SHALL clamp to [0, 2^DATA_W-1] unsigned or [-2^(DATA_W-1), 2^(DATA_W-1)-1] signed, with out_sat = 1 iff clamped.
REQ-014 out_data and out_sat SHALL be registered; out_valid SHALL rise the cycle after the Nth beat is accepted (latency 1).
REQ-015 In HOLD, out_valid = 1 and out_data/out_sat SHALL be held stable until out_ready; on out_valid && out_ready, next state is IDLE and out_valid drops next cycle.
REQ-016 Throughput SHALL be one result per N+1 cycles minimum, with no beat accepted in HOLD.
REQ-017 in_valid low in ACCUM SHALL stall with acc and cnt unchanged; there is no timeout.
REQ-018 clear SHALL have highest priority in any state: next cycle state = IDLE, acc = 0, cnt = 0, out_valid = 0; a beat presented with clear is discarded.
REQ-019 out_data and out_sat SHALL keep their last value after the handshake; they are only meaningful while out_valid = 1.

Reset
REQ-020 While rst_n = 0 the block SHALL set state = IDLE, acc = 0, cnt = 0, out_valid = 0, out_data = 0, out_sat = 0 and busy = 0, and drive in_ready = 1.
REQ-021 Reset asserted mid-window or in HOLD SHALL discard all partial state; the first accepted beat after release starts a new window.

Verification
REQ-022 Unsigned, shift=0, 27 beats of data=1, weight=1 -> out_data=27, out_sat=0, out_valid one cycle after the 27th beat.
REQ-023 Unsigned, 27 beats of data=255, weight=255: shift=0 -> out_data=255, out_sat=1; shift=16 -> out_data=26, out_sat=0.
REQ-024 Signed, shift=0, 27 beats of data=0xFF (-1), weight=0x02 -> out_data=0xCA (-54), out_sat=0; same with weight=0x7F -> out_data=0x80, out_sat=1.
REQ-025 Backpressure: out_ready low for 5 cycles in HOLD -> out_valid, out_data and out_sat stable, in_ready=0; in_valid gaps of 3 cycles mid-window -> same result as gapless.
REQ-026 Abort: clear after 10 beats, or rst_n pulse after 10 beats -> no out_valid; the next 27 beats of 1x1 produce out_data=27.

Source files
------------

// File: rtl/conv_mac_stream.sv
// ---------------------------------------------------------------------------
// conv_mac_stream
//
// Streaming multiply-accumulate for one convolution window. Activation/weight
// pairs arrive one per handshake; after N = K*K*CH pairs the accumulated sum
// is right-shifted, saturated to DATA_W bits and presented on the output
// handshake. The window's arithmetic mode and shift are captured with its
// first beat.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   clear        synchronous abort of the current window (highest priority)
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   shift        right shift applied to the final sum
//   in_valid     activation/weight pair valid
//   in_ready     block can accept a pair (low only while holding a result)
//   in_data      activation element
//   in_weight    weight element
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   out_data     scaled, saturated result (registered)
//   out_sat      out_data was clamped (registered)
//   busy         window in progress (state != IDLE)
// ---------------------------------------------------------------------------
module conv_mac_stream #(
    parameter int DATA_W = 8,
    parameter int K      = 3,
    parameter int CH     = 3,
    parameter int ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     signed_mode,
    input  logic [$clog2(ACC_W)-1:0] shift,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [DATA_W-1:0]        in_weight,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_sat,
    output logic                     busy
);

    localparam int N       = K * K * CH;
    localparam int CNT_W   = $clog2(N + 1);
    localparam int SHIFT_W = $clog2(ACC_W);
    localparam int PROD_W  = 2 * DATA_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mode;
    logic [SHIFT_W-1:0] r_shift;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_sat;

    // ------------------------------------------------------------------
    // Datapath wires
    // ------------------------------------------------------------------
    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_last;
    logic                     w_mode;
    logic [SHIFT_W-1:0]       w_shift;
    logic signed [PROD_W-1:0] w_prod_s;
    logic [PROD_W-1:0]        w_prod_u;
    logic [ACC_W-1:0]         w_prod_ext;
    logic [ACC_W-1:0]         w_sum;
    logic [ACC_W-1:0]         w_shifted;
    logic                     w_fit;
    logic [DATA_W-1:0]        w_sat_val;
    logic [DATA_W-1:0]        w_res;

    assign w_in_ready = (r_state != S_HOLD);
    assign w_accept   = in_valid && w_in_ready;

    // The first beat of a window uses the live mode/shift; later beats use
    // the copies captured with that first beat.
    assign w_mode  = (r_state == S_IDLE) ? signed_mode : r_mode;
    assign w_shift = (r_state == S_IDLE) ? shift       : r_shift;

    // Beat that completes the window (covers the degenerate N == 1 case).
    assign w_last = ((r_state == S_IDLE)  && (N == 1)) ||
                    ((r_state == S_ACCUM) && (r_cnt == CNT_W'(N - 1)));

    // Product in both interpretations, extended to the accumulator width.
    assign w_prod_s   = $signed(in_data) * $signed(in_weight);
    assign w_prod_u   = in_data * in_weight;
    assign w_prod_ext = w_mode ? ACC_W'(w_prod_s) : ACC_W'(w_prod_u);

    // Accumulation wraps modulo 2^ACC_W.
    assign w_sum = (r_state == S_IDLE) ? w_prod_ext : (r_acc + w_prod_ext);

    // Arithmetic shift floors toward minus infinity in signed mode.
    assign w_shifted = w_mode ? ACC_W'($signed(w_sum) >>> w_shift)
                              : (w_sum >> w_shift);

    // Saturation: a signed result fits when all bits from DATA_W-1 upward
    // equal the sign; an unsigned one when all bits from DATA_W upward are 0.
    always_comb begin
        w_fit     = 1'b1;
        w_sat_val = '1;
        if (w_mode) begin
            w_fit = (w_shifted[ACC_W-1:DATA_W-1] == '0) ||
                    (w_shifted[ACC_W-1:DATA_W-1] == '1);
            w_sat_val = w_shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                           : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            w_fit     = (w_shifted[ACC_W-1:DATA_W] == '0);
            w_sat_val = '1;
        end
    end

    assign w_res = w_fit ? w_shifted[DATA_W-1:0] : w_sat_val;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_last ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_accept && w_last) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_mode     <= 1'b0;
            r_shift    <= '0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else if (clear) begin
            // Abort discards any beat presented this cycle; the last result
            // registers are left as they were.
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_acc <= w_sum;
                if (r_state == S_IDLE) begin
                    r_cnt   <= CNT_W'(1);
                    r_mode  <= signed_mode;
                    r_shift <= shift;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_last) begin
                    r_out_data <= w_res;
                    r_out_sat  <= ~w_fit;
                end
            end else if ((r_state == S_HOLD) && out_ready) begin
                r_acc <= '0;
                r_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == S_HOLD);
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_conv_mac_stream.sv
// ---------------------------------------------------------------------------
// tb_conv_mac_stream
//
// Directed, table-driven bench for conv_mac_stream with default parameters
// (DATA_W=8, K=3, CH=3, ACC_W=24, N=27). Expected results are hand-computed
// constants in the vector table; abort and reset cases are hand-written
// sequences.
// ---------------------------------------------------------------------------
module tb_conv_mac_stream;

    localparam int N = 27;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       signed_mode;
    logic [4:0] shift;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] in_weight;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sat;
    logic       busy;

    int errors = 0;
    int checks = 0;

    conv_mac_stream #(
        .DATA_W (8),
        .K      (3),
        .CH     (3),
        .ACC_W  (24)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .signed_mode (signed_mode),
        .shift       (shift),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_weight   (in_weight),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sm;       // signed_mode for the window
        logic [4:0] sh;       // shift for the window
        logic [7:0] d;        // activation, repeated N times
        logic [7:0] w;        // weight, repeated N times
        int         gap;      // idle cycles between beats
        int         hold;     // cycles with out_ready low in HOLD
        bit         scramble; // change mode/shift after the first beat
        logic [7:0] ed;       // expected out_data
        logic       es;       // expected out_sat
    } vec_t;

    vec_t tbl [0:12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Full window from the table, through HOLD and the output handshake.
    task automatic run_row(input int idx, input vec_t v);
        string p;
        p = $sformatf("row%0d", idx);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (i == N - 1) chk({p, " out_valid before last beat"}, 32'(out_valid), 0);
            chk({p, " in_ready during window"}, 32'(in_ready), 1);
            in_valid  = 1'b1;
            in_data   = v.d;
            in_weight = v.w;
            if (v.scramble && i > 0) begin
                signed_mode = ~v.sm;
                shift       = v.sh + 5'd7;
            end else begin
                signed_mode = v.sm;
                shift       = v.sh;
            end
            @(posedge clk);
            if (i < N - 1) begin
                for (int g = 0; g < v.gap; g++) begin
                    @(negedge clk);
                    in_valid  = 1'b0;
                    in_data   = 8'hA5;
                    in_weight = 8'h5A;
                    @(posedge clk);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk({p, " out_valid latency"}, 32'(out_valid), 1);
        chk({p, " out_data"}, 32'(out_data), 32'(v.ed));
        chk({p, " out_sat"}, 32'(out_sat), 32'(v.es));
        chk({p, " in_ready in HOLD"}, 32'(in_ready), 0);
        chk({p, " busy in HOLD"}, 32'(busy), 1);
        for (int h = 0; h < v.hold; h++) begin
            // Offer a beat that must be refused while the result is held.
            in_valid  = 1'b1;
            in_data   = 8'h33;
            in_weight = 8'h44;
            @(negedge clk);
            chk({p, " held out_valid"}, 32'(out_valid), 1);
            chk({p, " held out_data"}, 32'(out_data), 32'(v.ed));
            chk({p, " held out_sat"}, 32'(out_sat), 32'(v.es));
            chk({p, " held in_ready"}, 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({p, " out_valid after handshake"}, 32'(out_valid), 0);
        chk({p, " busy after handshake"}, 32'(busy), 0);
        chk({p, " in_ready after handshake"}, 32'(in_ready), 1);
        chk({p, " out_data kept"}, 32'(out_data), 32'(v.ed));
    endtask

    // n beats of 1x1, unsigned, shift 0; leaves in_valid low.
    task automatic partial(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            in_data     = 8'd1;
            in_weight   = 8'd1;
            signed_mode = 1'b0;
            shift       = 5'd0;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, " in_ready"}, 32'(in_ready), 1);
        chk({p, " busy"}, 32'(busy), 0);
        chk({p, " out_valid"}, 32'(out_valid), 0);
        chk({p, " out_data"}, 32'(out_data), 0);
        chk({p, " out_sat"}, 32'(out_sat), 0);
    endtask

    initial begin
        //           sm    sh     d      w      gap hold scr ed     es
        tbl[0]  = '{1'b0, 5'd0,  8'h01, 8'h01, 0,  0,   0,  8'd27, 1'b0};
        tbl[1]  = '{1'b0, 5'd0,  8'hFF, 8'hFF, 0,  5,   0,  8'hFF, 1'b1};
        tbl[2]  = '{1'b0, 5'd16, 8'hFF, 8'hFF, 0,  0,   0,  8'd26, 1'b0};
        tbl[3]  = '{1'b1, 5'd0,  8'hFF, 8'h02, 0,  0,   0,  8'hCA, 1'b0};
        tbl[4]  = '{1'b1, 5'd0,  8'hFF, 8'h7F, 0,  0,   0,  8'h80, 1'b1};
        tbl[5]  = '{1'b0, 5'd0,  8'h01, 8'h01, 3,  5,   0,  8'd27, 1'b0};
        tbl[6]  = '{1'b1, 5'd2,  8'hFF, 8'h02, 0,  0,   0,  8'hF2, 1'b0};
        tbl[7]  = '{1'b1, 5'd0,  8'h7F, 8'h7F, 0,  0,   0,  8'h7F, 1'b1};
        tbl[8]  = '{1'b0, 5'd8,  8'h10, 8'h10, 0,  0,   0,  8'd27, 1'b0};
        tbl[9]  = '{1'b1, 5'd0,  8'hFF, 8'h02, 0,  0,   1,  8'hCA, 1'b0};
        tbl[10] = '{1'b0, 5'd23, 8'hFF, 8'hFF, 0,  0,   0,  8'h00, 1'b0};
        tbl[11] = '{1'b1, 5'd0,  8'h80, 8'h80, 1,  0,   0,  8'h7F, 1'b1};
        tbl[12] = '{1'b1, 5'd12, 8'h80, 8'h7F, 0,  0,   0,  8'h94, 1'b0};

        rst_n       = 1'b0;
        clear       = 1'b0;
        signed_mode = 1'b0;
        shift       = 5'd0;
        in_valid    = 1'b0;
        in_data     = 8'd0;
        in_weight   = 8'd0;
        out_ready   = 1'b0;

        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r <= 12; r++) run_row(r, tbl[r]);

        // Clear mid-window; the beat presented with clear is discarded.
        partial(10);
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'd1;
        in_weight = 8'd1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clear mid busy", 32'(busy), 0);
        chk("clear mid out_valid", 32'(out_valid), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("clear mid idle out_valid", 32'(out_valid), 0);
        end
        run_row(100, tbl[0]);

        // Reset pulse mid-window; out_data from the last window is 27.
        partial(10);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst mid");
        @(negedge clk);
        rst_n = 1'b1;
        run_row(101, tbl[0]);

        // Reset while holding a result.
        partial(N);
        chk("pre-rst hold out_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst hold");
        @(negedge clk);
        rst_n = 1'b1;
        run_row(102, tbl[3]);

        // Clear while holding a result.
        partial(N);
        chk("pre-clear hold out_valid", 32'(out_valid), 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear hold out_valid", 32'(out_valid), 0);
        chk("clear hold busy", 32'(busy), 0);
        chk("clear hold in_ready", 32'(in_ready), 1);
        run_row(103, tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
